// File: rtl/sys_bridge.sv
// CPU-to-peripheral bridge: word decode, one-hot write strobes, masked interrupt pending.
// Optional unmapped-access error flag: define SYS_BRIDGE_ERR_EN.
module sys_bridge #(
  parameter int          NUM_DEV   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter logic [7:0]  CTRL_OFF  = 8'hF0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_err,
  output logic                    cpu_int,
  output logic [1:0]              dev_add,
  output logic [31:0]             dev_data_in,
  output logic [NUM_DEV-1:0]      dev_write_en,
  input  logic [32*NUM_DEV-1:0]   dev_data_out,
  input  logic [NUM_DEV-1:0]      dev_int
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic               lat_we;
  logic [31:2]        lat_addr;
  logic [31:0]        lat_wdata;
  logic [31:0]        rdata_q;
  logic [NUM_DEV-1:0] pending;
  logic [NUM_DEV-1:0] mask;
  logic [NUM_DEV-1:0] int_hist;
  logic [NUM_DEV-1:0] rise;
  logic [NUM_DEV-1:0] pend_clr;

  logic [3:0]  idx;
  logic [8:0]  off9;
  logic        win_hit;
  logic        ctrl_hit;
  logic        ctrl_word;
  logic        dev_hit;
  logic        in_acc;
  logic [31:0] dev_rd;
  logic [31:0] acc_rd;
  logic        unused_addr;

  assign unused_addr = ^cpu_addr[1:0];

  assign idx     = lat_addr[7:4];
  assign off9    = {1'b0, lat_addr[7:2], 2'b00};
  assign win_hit = lat_addr[31:8] == BASE_ADDR[31:8];

  assign ctrl_hit = win_hit
                 && off9 >= {1'b0, CTRL_OFF}
                 && off9 <  {1'b0, CTRL_OFF} + 9'd8;
  // word 0 = pending, word 1 = mask
  assign ctrl_word = lat_addr[2] ^ CTRL_OFF[2];

  assign dev_hit = win_hit && !ctrl_hit
                && ({28'd0, idx} < 32'(NUM_DEV));

  assign in_acc = state == ACCESS;

  assign dev_add     = lat_addr[3:2];
  assign dev_data_in = lat_wdata;

  assign cpu_ready = state == RESP;
  assign cpu_rdata = cpu_ready ? rdata_q : '0;
  assign cpu_int   = |(pending & mask);

  assign rise     = dev_int & ~int_hist;
  assign pend_clr = (in_acc && lat_we && ctrl_hit && !ctrl_word)
                  ? lat_wdata[NUM_DEV-1:0] : '0;

  always_comb begin
    dev_rd       = '0;
    dev_write_en = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (idx == 4'(i)) begin
        dev_rd = dev_data_out[32*i +: 32];
        if (in_acc && lat_we && dev_hit)
          dev_write_en[i] = 1'b1;
      end
    end
  end

  always_comb begin
    acc_rd = '0;
    unique case (1'b1)
      dev_hit:  acc_rd = dev_rd;
      ctrl_hit: acc_rd = ctrl_word
                       ? {{(32-NUM_DEV){1'b0}}, mask}
                       : {{(32-NUM_DEV){1'b0}}, pending};
      default:  acc_rd = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cpu_req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      pending   <= '0;
      mask      <= '0;
      int_hist  <= '0;
    end else begin
      state    <= state_nx;
      int_hist <= dev_int;
      // a new edge wins over a same-cycle W1C
      pending  <= (pending & ~pend_clr) | rise;
      if (state == IDLE && cpu_req) begin
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr[31:2];
        lat_wdata <= cpu_wdata;
      end
      if (in_acc) begin
        rdata_q <= lat_we ? '0 : acc_rd;
        if (lat_we && ctrl_hit && ctrl_word)
          mask <= lat_wdata[NUM_DEV-1:0];
      end
    end
  end

`ifdef SYS_BRIDGE_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (in_acc)
      err_q <= !(dev_hit || ctrl_hit);
  end

  assign cpu_err = cpu_ready & err_q;
`else
  assign cpu_err = 1'b0;
`endif

endmodule
